// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings (parity modes, rx FSM states, status bit indices)
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        CHECK
    } rx_state_e;

    localparam int ERR_PARITY  = 0;
    localparam int ERR_START   = 1;
    localparam int ERR_STOP    = 2;
    localparam int ERR_OVERRUN = 3;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: STAGES-deep synchroniser for the serial line, resets to idle-high
// Ports: clk, reset (sync, active-high), d (async input), q (synchronised output)
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer with checker handshake and one-entry holding buffer
// Ports: clk, reset (sync, active-high), baud_tick (OVERSAMPLE x baud pulse), rx_en, rx_in (async line),
//        parity_type; chk_* frame fields to the error checker and chk_error verdict back;
//        rx_data/rx_status/rx_valid/rx_ready consumer handshake; busy while a frame is in progress
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       rx_en,
    input  logic       rx_in,
    input  logic [1:0] parity_type,
    output logic       chk_rx_flag,
    output logic       chk_start_bit,
    output logic       chk_stop_bit,
    output logic       chk_parity_bit,
    output logic [7:0] chk_raw_data,
    input  logic [2:0] chk_error,
    output logic [7:0] rx_data,
    output logic [3:0] rx_status,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic rxs;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_in),
        .q     (rxs)
    );

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    par_q, par_d;
    logic          armed_q, armed_d;
    logic          start_q, start_d;
    logic          stop_q, stop_d;
    logic          parity_q, parity_d;
    logic [7:0]    raw_q, raw_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    status_q, status_d;
    logic          valid_q, valid_d;
    logic          samp, flag;

    always_comb begin
        // START samples at mid-bit; every later sample is one full bit period on
        samp      = baud_tick && (cnt_q == ((state_q == START) ? MID : LAST));
        flag      = (state_q == CHECK) && rx_en;
        state_d   = state_q;
        cnt_d     = baud_tick ? (samp ? '0 : cnt_q + 1'b1) : cnt_q;
        bit_d     = bit_q;
        par_d     = par_q;
        // a low stop sample disarms start detection until the line returns high (break)
        armed_d   = armed_q | rxs;
        start_d   = start_q;
        stop_d    = stop_q;
        parity_d  = parity_q;
        raw_d     = raw_q;
        data_d    = data_q;
        status_d  = status_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_en && !rxs && armed_q) begin
                    state_d  = START;
                    par_d    = parity_type;
                    parity_d = 1'b0;
                end
            end
            START: if (samp) begin
                state_d = rxs ? IDLE : DATA;
                start_d = rxs ? start_q : 1'b0;
                bit_d   = '0;
            end
            DATA: if (samp) begin
                raw_d = {rxs, raw_q[7:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'd7)
                    state_d = (par_q == PAR_ODD || par_q == PAR_EVEN) ? PARITY : STOP;
            end
            PARITY: if (samp) begin
                parity_d = rxs;
                state_d  = STOP;
            end
            STOP: if (samp) begin
                stop_d  = rxs;
                armed_d = rxs;
                state_d = CHECK;
            end
            default: state_d = IDLE;
        endcase
        if (!rx_en && state_q != IDLE) state_d = IDLE;
        if (flag && (!valid_q || rx_ready)) begin
            data_d   = raw_q;
            status_d = {1'b0, chk_error};
            valid_d  = 1'b1;
        end else if (flag) begin
            status_d[ERR_OVERRUN] = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            par_q    <= '0;
            armed_q  <= 1'b1;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            parity_q <= 1'b0;
            raw_q    <= '0;
            data_q   <= '0;
            status_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            par_q    <= par_d;
            armed_q  <= armed_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            parity_q <= parity_d;
            raw_q    <= raw_d;
            data_q   <= data_d;
            status_q <= status_d;
            valid_q  <= valid_d;
        end
    end

    assign chk_rx_flag    = flag;
    assign chk_start_bit  = start_q;
    assign chk_stop_bit   = stop_q;
    assign chk_parity_bit = parity_q;
    assign chk_raw_data   = raw_q;
    assign rx_data        = data_q;
    assign rx_status      = status_q;
    assign rx_valid       = valid_q;
    assign busy           = state_q != IDLE;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed plus randomized frames checked against a frame-level buffer model
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_en = 1'b0;
    logic       rx_in = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic [2:0] chk_error = 3'b000;
    logic       rx_ready = 1'b0;
    logic       chk_rx_flag, chk_start_bit, chk_stop_bit, chk_parity_bit;
    logic [7:0] chk_raw_data, rx_data;
    logic [3:0] rx_status;
    logic       rx_valid, busy;

    int ncmp = 0;
    int nerr = 0;
    int tc = 0;
    int fl, bz;

    logic       exp_valid;
    logic [7:0] exp_data;
    logic [3:0] exp_status;

    uart_rx_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .baud_tick      (baud_tick),
        .rx_en          (rx_en),
        .rx_in          (rx_in),
        .parity_type    (parity_type),
        .chk_rx_flag    (chk_rx_flag),
        .chk_start_bit  (chk_start_bit),
        .chk_stop_bit   (chk_stop_bit),
        .chk_parity_bit (chk_parity_bit),
        .chk_raw_data   (chk_raw_data),
        .chk_error      (chk_error),
        .rx_data        (rx_data),
        .rx_status      (rx_status),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tc = (tc == 2) ? 0 : tc + 1;
            baud_tick = (tc == 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!baud_tick);
        end
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx_in = v;
        wait_ticks(16);
    endtask

    task automatic watch(input int ncyc, output int f, output int b);
        f = 0;
        b = 0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            f += int'(chk_rx_flag);
            b += int'(busy);
        end
    endtask

    function automatic logic par_bit(input logic [7:0] b, input logic [1:0] pt);
        return (pt == 2'b01) ? ~^b : (pt == 2'b10) ? ^b : 1'b0;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_data"}, rx_data, 0);
        check({tag, "_status"}, rx_status, 0);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_flag"}, chk_rx_flag, 0);
        check({tag, "_raw"}, chk_raw_data, 0);
        check({tag, "_pbit"}, chk_parity_bit, 0);
        check({tag, "_sbit"}, chk_stop_bit, 0);
        check({tag, "_stbit"}, chk_start_bit, 0);
        exp_valid = 1'b0;
        exp_data = 8'h00;
        exp_status = 4'h0;
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        exp_valid = 1'b0;
        check("accept_valid", rx_valid, 0);
    endtask

    task automatic frame(input logic [7:0] b, input logic [1:0] pt, input logic [2:0] err,
                         input logic stop_v, input logic rdy);
        int n;
        int f, bb;
        logic dlv;
        parity_type = pt;
        chk_error = err;
        send_bit(1'b0);
        parity_type = 2'($urandom);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (pt == 2'b01 || pt == 2'b10) send_bit(par_bit(b, pt));
        rx_in = stop_v;
        n = 0;
        while (!chk_rx_flag && n < 400) begin
            step();
            n++;
        end
        check("flag_seen", chk_rx_flag, 1);
        check("raw_data", chk_raw_data, b);
        check("parity_bit", chk_parity_bit, par_bit(b, pt));
        check("stop_bit", chk_stop_bit, stop_v);
        check("start_bit", chk_start_bit, 0);
        check("valid_before", rx_valid, exp_valid);
        dlv = !exp_valid || rdy;
        rx_ready = rdy;
        step();
        rx_ready = 1'b0;
        if (dlv) begin
            exp_data = b;
            exp_status = {1'b0, err};
            exp_valid = 1'b1;
        end else begin
            exp_status[3] = 1'b1;
        end
        check("flag_one_cycle", chk_rx_flag, 0);
        check("rx_valid", rx_valid, exp_valid);
        check("rx_data", rx_data, exp_data);
        check("rx_status", rx_status, exp_status);
        watch(30, f, bb);
        check("post_frame_flag", f, 0);
        check("post_frame_busy", bb, 0);
        rx_in = 1'b1;
        wait_ticks(4);
    endtask

    initial begin
        logic [7:0] b;
        logic [1:0] pt;
        logic [2:0] err;
        logic       sv, rdy;
        rx_en = 1'b1;
        reset = 1'b1;
        repeat (3) step();
        check_zero("reset");
        reset = 1'b0;
        wait_ticks(4);

        frame(8'hA5, 2'b00, 3'b000, 1'b1, 1'b0);
        accept();
        frame(8'h3C, 2'b01, 3'b001, 1'b1, 1'b0);
        accept();

        rx_in = 1'b0;
        wait_ticks(4);
        rx_in = 1'b1;
        watch(120, fl, bz);
        check("glitch_flag", fl, 0);
        check("glitch_busy_pulse", bz != 0, 1);
        check("glitch_idle", busy, 0);
        check("glitch_valid", rx_valid, 0);

        frame(8'h11, 2'b00, 3'b000, 1'b1, 1'b0);
        frame(8'h22, 2'b00, 3'b000, 1'b1, 1'b0);
        accept();
        frame(8'h11, 2'b00, 3'b000, 1'b1, 1'b0);
        frame(8'h22, 2'b00, 3'b000, 1'b1, 1'b1);

        parity_type = 2'b00;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        rx_in = 1'b1;
        wait_ticks(4);
        check("mid_data_busy", busy, 1);
        reset = 1'b1;
        step();
        check_zero("reset_mid");
        reset = 1'b0;
        wait_ticks(20);
        frame(8'h5A, 2'b10, 3'b000, 1'b1, 1'b0);

        b = 8'hC3;
        parity_type = 2'b10;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        rx_in = par_bit(b, 2'b10);
        wait_ticks(4);
        check("parity_busy", busy, 1);
        rx_en = 1'b0;
        step();
        check("en_drop_busy", busy, 0);
        rx_in = 1'b1;
        watch(60, fl, bz);
        check("en_drop_flag", fl, 0);
        rx_en = 1'b1;
        check("en_drop_valid", rx_valid, exp_valid);
        check("en_drop_data", rx_data, exp_data);
        check("en_drop_status", rx_status, exp_status);
        wait_ticks(4);

        accept();
        frame(8'h00, 2'b00, 3'b100, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            pt = 2'($urandom);
            err = 3'($urandom);
            sv = ($urandom_range(0, 3) != 0);
            rdy = 1'($urandom_range(0, 1));
            frame(b, pt, err, sv, rdy);
            if ($urandom_range(0, 1) == 1) accept();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
